sprite_draw_ctrl: RTL and testbench

- Sequencing controller for the 5x5 player-sprite pixel datapath (x/y pixel counters, op-coded colour: draw/erase/fire).
- Owns sprite position and fire state.
- On each frame tick, runs an erase pass at the old position, updates state, then runs a draw pass at the new position.
- Drives the datapath's enable/op/origin and the VGA plot strobe.

---
 rtl/sprite_draw_ctrl_if.sv | 51 +++++
 rtl/sprite_draw_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_sprite_draw_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_draw_ctrl_if.sv
// -----------------------------------------------------------------------------
// sprite_draw_ctrl_if
// Bundles the player-sprite controller's request inputs and datapath/VGA
// outputs so the controller and its driver connect through one port.
//
// Signal contract: there is no valid/ready handshake on this bundle.
// frame_tick is a one-cycle pulse that is accepted only while the controller
// is idle (busy=0) and is dropped otherwise. move_left/move_right/fire_btn
// are sticky requests: any cycle at 1 latches a pending flag that lives until
// the next accepted tick. dp_enable/plot are qualified by busy and are only
// ever high inside a 25-cycle erase or draw pass.
//
//   frame_tick  ctrl <- src  one-cycle pulse per video frame
//   move_left   ctrl <- src  move request, left
//   move_right  ctrl <- src  move request, right
//   fire_btn    ctrl <- src  fire request
//   x_pos       ctrl -> dp   sprite origin x (8b)
//   y_pos       ctrl -> dp   sprite origin y (8b)
//   op          ctrl -> dp   00 draw, 01 erase, 10 fire
//   dp_enable   ctrl -> dp   datapath pixel counter enable
//   plot        ctrl -> vga  pixel write strobe
//   busy        ctrl -> src  erase/draw pass in progress
//   fire_active ctrl -> src  fire shape currently displayed
//   dbg_state   ctrl -> dbg  encoded FSM state
// -----------------------------------------------------------------------------
interface sprite_draw_ctrl_if;
   logic       frame_tick;
   logic       move_left;
   logic       move_right;
   logic       fire_btn;
   logic [7:0] x_pos;
   logic [7:0] y_pos;
   logic [1:0] op;
   logic       dp_enable;
   logic       plot;
   logic       busy;
   logic       fire_active;
   logic [2:0] dbg_state;

   // Controller side
   modport slave (
      input  frame_tick, move_left, move_right, fire_btn,
      output x_pos, y_pos, op, dp_enable, plot, busy, fire_active, dbg_state
   );

   // Request source / observer side
   modport master (
      output frame_tick, move_left, move_right, fire_btn,
      input  x_pos, y_pos, op, dp_enable, plot, busy, fire_active, dbg_state
   );
endinterface

// File: rtl/sprite_draw_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_draw_ctrl
// Sequencing controller for the 5x5 player-sprite pixel datapath. Owns the
// sprite x position and fire state. On an accepted frame tick that changes
// what is on screen it runs a 25-cycle erase pass at the old position, a
// one-cycle update, then a 25-cycle draw pass at the new position.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (also resets the datapath counters)
//   bus      sprite_draw_ctrl_if.slave (requests in, datapath/VGA controls out)
//
// Optional feature: define SPRITE_DRAW_CTRL_FIRE_COOLDOWN_EN to add a
// cooldown counter that blocks a new fire for COOLDOWN_FRAMES accepted ticks
// after a fire ends.
// -----------------------------------------------------------------------------
module sprite_draw_ctrl #(
   parameter logic [7:0] X_INIT      = 8'd78,
   parameter logic [7:0] Y_INIT      = 8'd110,
   parameter logic [7:0] X_MIN       = 8'd0,
   parameter logic [7:0] X_MAX       = 8'd155,
   parameter logic [7:0] STEP        = 8'd1,
   parameter int         FIRE_FRAMES = 4
`ifdef SPRITE_DRAW_CTRL_FIRE_COOLDOWN_EN
   ,
   parameter int         COOLDOWN_FRAMES = 8
`endif
) (
   input logic               clk,
   input logic               reset_n,
   sprite_draw_ctrl_if.slave bus
);

   localparam int FC_W = $clog2(FIRE_FRAMES + 1);
   localparam logic [4:0] PASS_LAST = 5'd24;

   localparam logic [1:0] OP_DRAW  = 2'b00;
   localparam logic [1:0] OP_ERASE = 2'b01;
   localparam logic [1:0] OP_FIRE  = 2'b10;

   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_INIT_DRAW = 3'd1,
      S_IDLE      = 3'd2,
      S_ERASE     = 3'd3,
      S_UPDATE    = 3'd4,
      S_DRAW      = 3'd5
   } state_t;

   state_t          r_state;
   logic [4:0]      r_pix_cnt;
   logic [7:0]      r_x;
   logic [7:0]      r_nx;
   logic [FC_W-1:0] r_fire_cnt;
   logic [FC_W-1:0] r_nfc;
   logic            r_pend_l;
   logic            r_pend_r;
   logic            r_pend_f;
   logic [1:0]      r_op;
   logic            r_dp_enable;
   logic            r_plot;
   logic            r_busy;
   logic            r_fire_active;

`ifdef SPRITE_DRAW_CTRL_FIRE_COOLDOWN_EN
   localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
   logic [CD_W-1:0] r_cooldown;
`endif

   logic [8:0]      w_sum;
   logic [7:0]      w_nx;
   logic [FC_W-1:0] w_nfc;
   logic            w_fire_start;
   logic            w_redraw;

   // Tick evaluation: next position, next fire count and whether the screen
   // content changes. Arithmetic is 9 bits wide so a left step below X_MIN
   // clamps instead of wrapping.
   always_comb begin
      w_sum = {1'b0, r_x};
      w_nx  = r_x;
      if (r_pend_l && !r_pend_r) begin
         if ({1'b0, r_x} >= ({1'b0, X_MIN} + {1'b0, STEP})) begin
            w_sum = {1'b0, r_x} - {1'b0, STEP};
            w_nx  = w_sum[7:0];
         end else begin
            w_nx = X_MIN;
         end
      end else if (r_pend_r && !r_pend_l) begin
         w_sum = {1'b0, r_x} + {1'b0, STEP};
         if (w_sum > {1'b0, X_MAX}) begin
            w_nx = X_MAX;
         end else begin
            w_nx = w_sum[7:0];
         end
      end

      w_fire_start = r_pend_f && (r_fire_cnt == '0);
`ifdef SPRITE_DRAW_CTRL_FIRE_COOLDOWN_EN
      w_fire_start = w_fire_start && (r_cooldown == '0);
`endif

      if (w_fire_start) begin
         w_nfc = FC_W'(FIRE_FRAMES);
      end else if (r_fire_cnt != '0) begin
         w_nfc = r_fire_cnt - FC_W'(1);
      end else begin
         w_nfc = '0;
      end

      // fire_cnt==1 forces a redraw so the red tip is removed.
      w_redraw = (w_nx != r_x) || w_fire_start || (r_fire_cnt == FC_W'(1));
   end

   // Single FSM block. Outputs are registered and assigned together with the
   // state they belong to, so they change on the same edge as the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_RESET;
         r_pix_cnt     <= '0;
         r_x           <= X_INIT;
         r_nx          <= X_INIT;
         r_fire_cnt    <= '0;
         r_nfc         <= '0;
         r_pend_l      <= 1'b0;
         r_pend_r      <= 1'b0;
         r_pend_f      <= 1'b0;
         r_op          <= OP_DRAW;
         r_dp_enable   <= 1'b0;
         r_plot        <= 1'b0;
         r_busy        <= 1'b0;
         r_fire_active <= 1'b0;
`ifdef SPRITE_DRAW_CTRL_FIRE_COOLDOWN_EN
         r_cooldown    <= '0;
`endif
      end else begin
         case (r_state)
            S_RESET: begin
               r_state     <= S_INIT_DRAW;
               r_op        <= (r_fire_cnt != '0) ? OP_FIRE : OP_DRAW;
               r_dp_enable <= 1'b1;
               r_plot      <= 1'b1;
               r_busy      <= 1'b1;
            end

            S_INIT_DRAW, S_DRAW: begin
               if (r_pix_cnt == PASS_LAST) begin
                  r_pix_cnt   <= '0;
                  r_state     <= S_IDLE;
                  r_op        <= OP_DRAW;
                  r_dp_enable <= 1'b0;
                  r_plot      <= 1'b0;
                  r_busy      <= 1'b0;
               end else begin
                  r_pix_cnt <= r_pix_cnt + 5'd1;
               end
            end

            S_IDLE: begin
               if (bus.frame_tick) begin
`ifdef SPRITE_DRAW_CTRL_FIRE_COOLDOWN_EN
                  if (r_cooldown != '0) begin
                     r_cooldown <= r_cooldown - CD_W'(1);
                  end
`endif
                  if (w_redraw) begin
                     // Hold the evaluated result until the erase pass at
                     // the old position is finished.
                     r_nx        <= w_nx;
                     r_nfc       <= w_nfc;
                     r_state     <= S_ERASE;
                     r_op        <= OP_ERASE;
                     r_dp_enable <= 1'b1;
                     r_plot      <= 1'b1;
                     r_busy      <= 1'b1;
                  end else begin
                     r_fire_cnt    <= w_nfc;
                     r_fire_active <= (w_nfc != '0);
                     r_pend_l      <= 1'b0;
                     r_pend_r      <= 1'b0;
                     r_pend_f      <= 1'b0;
                  end
               end
            end

            S_ERASE: begin
               if (r_pix_cnt == PASS_LAST) begin
                  r_pix_cnt   <= '0;
                  r_state     <= S_UPDATE;
                  r_op        <= OP_DRAW;
                  r_dp_enable <= 1'b0;
                  r_plot      <= 1'b0;
               end else begin
                  r_pix_cnt <= r_pix_cnt + 5'd1;
               end
            end

            S_UPDATE: begin
               r_x           <= r_nx;
               r_fire_cnt    <= r_nfc;
               r_fire_active <= (r_nfc != '0);
               r_pend_l      <= 1'b0;
               r_pend_r      <= 1'b0;
               r_pend_f      <= 1'b0;
`ifdef SPRITE_DRAW_CTRL_FIRE_COOLDOWN_EN
               if ((r_fire_cnt == FC_W'(1)) && (r_nfc == '0)) begin
                  r_cooldown <= CD_W'(COOLDOWN_FRAMES);
               end
`endif
               r_state     <= S_DRAW;
               r_op        <= (r_nfc != '0) ? OP_FIRE : OP_DRAW;
               r_dp_enable <= 1'b1;
               r_plot      <= 1'b1;
            end

            default: begin
               r_state <= S_RESET;
            end
         endcase

         // Requests are latched in every state; placed last so a request in
         // the same cycle as a clear is not lost.
         if (bus.move_left) begin
            r_pend_l <= 1'b1;
         end
         if (bus.move_right) begin
            r_pend_r <= 1'b1;
         end
         if (bus.fire_btn) begin
            r_pend_f <= 1'b1;
         end
      end
   end

   assign bus.x_pos       = r_x;
   assign bus.y_pos       = Y_INIT;
   assign bus.op          = r_op;
   assign bus.dp_enable   = r_dp_enable;
   assign bus.plot        = r_plot;
   assign bus.busy        = r_busy;
   assign bus.fire_active = r_fire_active;
   assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_sprite_draw_ctrl.sv
module tb_sprite_draw_ctrl;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   sprite_draw_ctrl_if bus();

   sprite_draw_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;

   // Results captured by tick_window / init_window
   int         busy_cnt;
   int         en_cnt;
   int         plot_cnt;
   int         first_en;
   int         bad_px;
   logic [7:0] e_x;
   logic [7:0] d_x;
   logic [1:0] e_op;
   logic [1:0] d_op;
   logic       gap_en;
   logic       fa_end;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One-cycle request pulse, returns on the following negedge with inputs low.
   task automatic press(input logic l, input logic r, input logic f);
      @(negedge clk);
      bus.move_left  = l;
      bus.move_right = r;
      bus.fire_btn   = f;
      @(negedge clk);
      bus.move_left  = 1'b0;
      bus.move_right = 1'b0;
      bus.fire_btn   = 1'b0;
   endtask

   // Tick in cycle T, then observe T+1..T+60. Optional second tick at T+extra_at.
   task automatic tick_window(input int extra_at);
      @(negedge clk);
      bus.frame_tick = 1'b1;
      busy_cnt = 0;
      en_cnt   = 0;
      plot_cnt = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         bus.frame_tick = (i == extra_at);
         if (bus.busy)      busy_cnt++;
         if (bus.dp_enable) en_cnt++;
         if (bus.plot)      plot_cnt++;
         if (i == 1) begin
            e_x  = bus.x_pos;
            e_op = bus.op;
         end
         if (i == 26) gap_en = bus.dp_enable | bus.plot;
         if (i == 27) begin
            d_x  = bus.x_pos;
            d_op = bus.op;
         end
      end
      fa_end = bus.fire_active;
   endtask

   // Called right after reset_n is released on a negedge (cycle 0).
   task automatic init_window();
      busy_cnt = 0;
      en_cnt   = 0;
      plot_cnt = 0;
      first_en = 0;
      bad_px   = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (bus.busy)      busy_cnt++;
         if (bus.plot)      plot_cnt++;
         if (bus.dp_enable) begin
            en_cnt++;
            if (first_en == 0) first_en = i;
            if (bus.op !== 2'b00 || bus.x_pos !== 8'd78 || bus.y_pos !== 8'd110) bad_px++;
         end
      end
      check("init_en_cnt",   en_cnt,   25);
      check("init_plot_cnt", plot_cnt, 25);
      check("init_busy_cnt", busy_cnt, 25);
      check("init_first_en", first_en, 1);
      check("init_px_bad",   bad_px,   0);
      check("init_busy_end", bus.busy, 0);
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.frame_tick = 1'b0;
      bus.move_left  = 1'b0;
      bus.move_right = 1'b0;
      bus.fire_btn   = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_x",     bus.x_pos,       8'd78);
      check("rst_y",     bus.y_pos,       8'd110);
      check("rst_op",    bus.op,          2'b00);
      check("rst_en",    bus.dp_enable,   1'b0);
      check("rst_plot",  bus.plot,        1'b0);
      check("rst_busy",  bus.busy,        1'b0);
      check("rst_fire",  bus.fire_active, 1'b0);
      check("rst_state", bus.dbg_state,   3'd0);

      // Initial draw after release
      reset_n = 1'b1;
      check("rel_busy0", bus.busy, 1'b0);
      init_window();

      // Single move right: erase at 78, gap, draw at 79
      press(1'b0, 1'b1, 1'b0);
      tick_window(0);
      check("mr_busy_cnt", busy_cnt, 51);
      check("mr_en_cnt",   en_cnt,   50);
      check("mr_plot_cnt", plot_cnt, 50);
      check("mr_erase_x",  e_x,      8'd78);
      check("mr_erase_op", e_op,     2'b01);
      check("mr_gap_en",   gap_en,   1'b0);
      check("mr_draw_x",   d_x,      8'd79);
      check("mr_draw_op",  d_op,     2'b00);
      check("mr_x",        bus.x_pos, 8'd79);

      // Walk to the left edge and push past it
      for (int k = 0; k < 79; k++) begin
         press(1'b1, 1'b0, 1'b0);
         tick_window(0);
      end
      check("walk_l_x", bus.x_pos, 8'd0);
      press(1'b1, 1'b0, 1'b0);
      tick_window(0);
      check("min_busy_cnt", busy_cnt,  0);
      check("min_x",        bus.x_pos, 8'd0);

      // Walk to the right edge and push past it
      for (int k = 0; k < 155; k++) begin
         press(1'b0, 1'b1, 1'b0);
         tick_window(0);
      end
      check("walk_r_x", bus.x_pos, 8'd155);
      press(1'b0, 1'b1, 1'b0);
      tick_window(0);
      check("max_busy_cnt", busy_cnt,  0);
      check("max_x",        bus.x_pos, 8'd155);

      // Back to x=10
      for (int k = 0; k < 145; k++) begin
         press(1'b1, 1'b0, 1'b0);
         tick_window(0);
      end
      check("walk_10_x", bus.x_pos, 8'd10);

      // Fire together with a left move: one pass pair, drawn with op=10 at 9
      press(1'b1, 1'b0, 1'b1);
      tick_window(0);
      check("fire_busy_cnt", busy_cnt, 51);
      check("fire_erase_x",  e_x,      8'd10);
      check("fire_erase_op", e_op,     2'b01);
      check("fire_draw_x",   d_x,      8'd9);
      check("fire_draw_op",  d_op,     2'b10);
      check("fire_active1",  fa_end,   1'b1);

      // Three ticks that only count the fire down
      for (int k = 0; k < 3; k++) begin
         tick_window(0);
         check("fire_hold_busy", busy_cnt, 0);
         check("fire_hold_fa",   fa_end,   1'b1);
      end

      // Fourth tick removes the tip
      tick_window(0);
      check("fire_end_busy", busy_cnt, 51);
      check("fire_end_eop",  e_op,     2'b01);
      check("fire_end_dop",  d_op,     2'b00);
      check("fire_end_x",    d_x,      8'd9);
      check("fire_end_fa",   fa_end,   1'b0);

      // Tick during the draw pass is dropped
      press(1'b0, 1'b1, 1'b0);
      tick_window(30);
      check("midtick_busy_cnt", busy_cnt, 51);
      check("midtick_en_cnt",   en_cnt,   50);
      check("midtick_x",        bus.x_pos, 8'd10);

      // Left and right together: no move
      press(1'b1, 1'b1, 1'b0);
      tick_window(0);
      check("both_busy_cnt", busy_cnt,  0);
      check("both_x",        bus.x_pos, 8'd10);

      // Reset in the middle of an erase pass (pixel 12 = cycle T+13)
      press(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      bus.frame_tick = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         @(negedge clk);
         bus.frame_tick = 1'b0;
      end
      check("mid_erase_en", bus.dp_enable, 1'b1);
      check("mid_erase_op", bus.op,        2'b01);
      reset_n = 1'b0;
      #1;
      check("mid_rst_en",   bus.dp_enable, 1'b0);
      check("mid_rst_plot", bus.plot,      1'b0);
      check("mid_rst_busy", bus.busy,      1'b0);
      check("mid_rst_x",    bus.x_pos,     8'd78);
      check("mid_rst_op",   bus.op,        2'b00);
      @(negedge clk);
      reset_n = 1'b1;
      init_window();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
